// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller and its MDU timer.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int REG_ZERO = 0;

    // Counter must hold MDU_LAT itself, hence the +1.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// Tracks multiply/divide unit occupancy: busy for exactly MDU_LAT cycles after a start pulse.
//   state | meaning
//   IDLE  | MDU free, waiting for a start pulse
//   BUSY  | MDU computing, cnt counts remaining busy cycles down to 1
module mdu_busy_timer
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    output logic busy
);

    localparam int CW = cnt_width(MDU_LAT);

    mdu_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Keeps counting through pipeline freezes; only clr aborts an operation.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(MDU_LAT);
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage-register load/flush control and MDU launch for the 5-stage pipeline.
// Define HAZARD_PERF_EN to build the stall_cycles performance counter; otherwise it reads 0.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT    = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_mdu_op,
    input  logic                  id_hilo_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic                  br_taken_ex,
    input  logic                  ext_stall,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  mdu_start,
    output logic                  mdu_busy,
    output logic [31:0]           stall_cycles
);

    logic load_use;
    logic mdu_hazard;

    assign load_use = ex_mem_read
                    && (ex_rt != REG_ADDR_W'(REG_ZERO))
                    && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign mdu_hazard = mdu_busy && (id_mdu_op || id_hilo_read);

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_start  = 1'b0;
        if (clr) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ext_stall) begin
            // Full freeze; a taken branch stays in EX and is seen again next cycle.
        end else if (br_taken_ex) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use || mdu_hazard) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            idex_flush = 1'b1;
        end else begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            mdu_start = id_mdu_op;
        end
    end

    mdu_busy_timer #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_timer (
        .clk   (clk),
        .clr   (clr),
        .start (mdu_start),
        .busy  (mdu_busy)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cycles <= '0;
        end else if (!pc_en) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central controller for the 5-stage MIPS pipeline's stage registers (PC, IF/ID, ID/EX, EX/MEM).
- Decides every cycle which stage registers load, which are flushed to a bubble, and when the multi-cycle multiply/divide unit (MDU) starts.
- Tracks MDU occupancy with an internal state machine and counter, and stalls HI/LO consumers until the result is ready.

Parameters:
- MDU_LAT, 32, MDU busy cycles after a start; legal range ≥1.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset, synchronous, active-high
- id_rs  in  REG_ADDR_W  rs of instruction in ID
- id_rt  in  REG_ADDR_W  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_mdu_op  in  1  ID holds mult/multu/div/divu
- id_hilo_read  in  1  ID holds mfhi/mflo
- ex_rt  in  REG_ADDR_W  destination of instruction in EX
- ex_mem_read  in  1  EX holds a load
- br_taken_ex  in  1  branch/jump resolved taken in EX
- ext_stall  in  1  memory not ready; freeze the pipeline
- pc_en  out  1  PC load enable
- ifid_en  out  1  IF/ID load enable
- idex_en  out  1  ID/EX load enable
- exmem_en  out  1  EX/MEM load enable
- ifid_flush  out  1  IF/ID clear-to-NOP
- idex_flush  out  1  ID/EX clear-to-NOP
- mdu_start  out  1  one-cycle MDU launch pulse
- mdu_busy  out  1  MDU occupied (registered)
- stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- State machine: IDLE, BUSY. Counter cnt, width clog2(MDU_LAT+1).
- mdu_busy = (state==BUSY).
- Control outputs are combinational from the inputs plus state. They are evaluated in priority order; the first match wins:
  1. clr=1: all enables=0, ifid_flush=idex_flush=1, mdu_start=0. Next state IDLE, cnt=0, so mdu_busy=0 on the following cycle. This also applies when clr arrives mid-MDU.
  2. ext_stall=1: all enables=0, flushes=0, mdu_start=0. The MDU counter keeps counting. A simultaneous br_taken_ex is ignored this cycle; EX holds the branch, so it is re-presented next cycle.
  3. br_taken_ex=1: pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=idex_flush=1. No mdu_start, because the ID instruction is squashed.
  4. Load-use: ex_mem_read and ex_rt≠0 and (ex_rt==id_rs, or id_uses_rt and ex_rt==id_rt).
     - pc_en=ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1.
  5. MDU hazard: mdu_busy and (id_mdu_op or id_hilo_read). Same outputs as load-use.
  6. Otherwise: all enables=1, flushes=0. mdu_start=id_mdu_op.
- MDU timing:
  - mdu_start at cycle t loads cnt=MDU_LAT and sets state BUSY.
  - Each BUSY cycle: cnt-1. When cnt==1: state IDLE, cnt=0.
  - mdu_busy is high for exactly cycles t+1..t+MDU_LAT.
  - A queued mfhi/mult in ID issues at cycle t+MDU_LAT+1.
- Register $zero (address 0) never creates a load-use hazard.
- An id_mdu_op that is stalled by load-use is not started; it retries next cycle.
- mdu_start is never asserted while mdu_busy=1.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: stall_cycles is a 32-bit register.
  - Cleared by clr.
  - Increments every cycle with clr=0 and pc_en=0.
  - Wraps modulo 2^32.
- Undefined: stall_cycles tied to 0; no counter flops.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum {IDLE, BUSY}
  - REG_ZERO constant
  - cnt-width function clog2(MDU_LAT+1)
- Sub-module mdu_busy_timer contains the FSM and counter. Inputs: clk, clr, start. Outputs: busy.
- The hazard priority logic stays in the top level.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; with ex_rt=0 instead → no stall.
- Branch plus load-use in the same cycle: br_taken_ex=1 with a matching load → ifid_flush=idex_flush=1, pc_en=1.
- MDU with MDU_LAT=4: id_mdu_op at cycle 10 → mdu_start at 10, mdu_busy 11–14. An mfhi held in ID stalls cycles 11–14 and issues at 15.
- ext_stall held 3 cycles during BUSY (MDU_LAT=4) → all enables 0 for those cycles; mdu_busy still drops after 4 cycles.
- Reset mid-MDU: clr at busy cycle 2 → mdu_busy=0 the next cycle; outputs return to the "otherwise" case.
- HAZARD_PERF_EN defined: 5 stall cycles → stall_cycles=5. Undefined → stall_cycles stays 0.
